status_snapshot_ctrl: RTL and testbench

STATUS_SNAPSHOT_CTRL -- requirements
Module: status_snapshot_ctrl

---
 rtl/status_snapshot_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_status_snapshot_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_snapshot_ctrl.sv
// rtl/status_snapshot_ctrl.sv - periodic / on-demand coherent status snapshot into a dual-region word memory
//
// Purpose: captures N_CH status channels coherently, writes heartbeat, channel
// shadows and a sticky change word into the status region, accepts command
// words into the command region, and serves word-pair reads with 2-cycle latency.
//
// Ports:
//   sys_clk    single clock
//   rst        asynchronous active-high reset
//   cmd_en     command word write strobe (priority over scan writes)
//   cmd_addr   command region word address
//   cmd_data   command word
//   status_in  channel i in bits [i*DW +: DW]
//   snap_mode  0 = periodic trigger, 1 = on-demand trigger
//   snap_req   on-demand trigger pulse
//   chg_clr    clears the sticky change word
//   rd_en      read strobe
//   rd_addr    word-pair index
//   rd_data    {even word, odd word}
//   rd_vld     read data valid
//   busy       scan in progress
//   snap_done  one-cycle pulse at scan end
//   overrun    sticky: a trigger arrived while busy
module status_snapshot_ctrl #(
  parameter int N_CH   = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 128,
  parameter int PERIOD = 12500,
  parameter int AW     = 7
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               cmd_en,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [DW-1:0]      cmd_data,
  input  logic [N_CH*DW-1:0] status_in,
  input  logic               snap_mode,
  input  logic               snap_req,
  input  logic               chg_clr,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [2*DW-1:0]    rd_data,
  output logic               rd_vld,
  output logic               busy,
  output logic               snap_done,
  output logic               overrun
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_CH + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       period_cnt;
  logic [DW-1:0]       heartbeat;
  logic [N_CH*DW-1:0]  shadow_new;
  logic [N_CH*DW-1:0]  shadow_prev;
  logic [DW-1:0]       chg_reg;
  logic [AW-1:0]       idx;

  // Word w lives in bank w[0] at row w>>1, so one pair read is one row of each bank.
  logic [DW-1:0]       mem_even [DEPTH];
  logic [DW-1:0]       mem_odd  [DEPTH];

  logic                trigger;
  logic [DW-1:0]       chg_vec;
  logic [DW-1:0]       chg_word;
  logic [DW-1:0]       scan_word;
  logic                we;
  logic [AW:0]         waddr;
  logic [DW-1:0]       wdata;
  logic [2*DW-1:0]     rd_q;
  logic                rd_q_vld;

  assign trigger = snap_mode ? snap_req : (period_cnt == '0);

  // Shadows are stable for the whole WRITE phase, so the change vector is a
  // plain compare of the two shadow generations.
  always_comb begin
    chg_vec = '0;
    for (int i = 0; i < N_CH; i++)
      chg_vec[i] = (shadow_new[i*DW +: DW] != shadow_prev[i*DW +: DW]);
  end

  // A clear landing on the change-word write drops the accumulated history.
  assign chg_word = (chg_clr ? '0 : chg_reg) | chg_vec;

  always_comb begin
    scan_word = heartbeat;
    if (idx == LAST_IDX)
      scan_word = chg_word;
    for (int i = 0; i < N_CH; i++)
      if (idx == AW'(i + 1))
        scan_word = shadow_new[i*DW +: DW];
  end

  // Single write port: a command write wins and the scan index simply waits.
  always_comb begin
    we    = cmd_en || (state == WRITE);
    waddr = cmd_en ? {1'b1, cmd_addr} : {1'b0, idx};
    wdata = cmd_en ? cmd_data : scan_word;
  end

  always_ff @(posedge sys_clk) begin
    if (we) begin
      if (waddr[0])
        mem_odd[waddr[AW:1]] <= wdata;
      else
        mem_even[waddr[AW:1]] <= wdata;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      period_cnt  <= '0;
      heartbeat   <= '0;
      shadow_new  <= '0;
      shadow_prev <= '0;
      chg_reg     <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      snap_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      period_cnt <= (period_cnt == CW'(PERIOD - 1)) ? '0 : period_cnt + CW'(1);
      snap_done  <= 1'b0;
      if (chg_clr)
        chg_reg <= '0;
      if (trigger && busy)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          idx <= '0;
          if (trigger) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          shadow_new  <= status_in;
          shadow_prev <= shadow_new;
          heartbeat   <= heartbeat + DW'(1);
          idx         <= '0;
          state       <= WRITE;
        end
        WRITE: begin
          if (!cmd_en) begin
            if (idx == LAST_IDX) begin
              chg_reg   <= chg_word;
              state     <= DONE;
              snap_done <= 1'b1;
            end else begin
              idx <= idx + AW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage read: the memory sample is taken with the write on the same edge,
  // so a coinciding write is not visible to this read.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      rd_q_vld <= 1'b0;
      rd_data  <= '0;
      rd_vld   <= 1'b0;
    end else begin
      rd_q_vld <= rd_en;
      if (rd_en)
        rd_q <= {mem_even[rd_addr], mem_odd[rd_addr]};
      rd_vld <= rd_q_vld;
      if (rd_q_vld)
        rd_data <= rd_q;
    end
  end

endmodule

// File: tb/tb_status_snapshot_ctrl.sv
// tb/tb_status_snapshot_ctrl.sv - self-checking bench for status_snapshot_ctrl
module tb_status_snapshot_ctrl;

  localparam int N_CH   = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 128;
  localparam int PERIOD = 64;
  localparam int AW     = 7;

  logic               sys_clk = 1'b0;
  logic               rst;
  logic               cmd_en;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_data;
  logic [N_CH*DW-1:0] status_in;
  logic               snap_mode;
  logic               snap_req;
  logic               chg_clr;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [2*DW-1:0]    rd_data;
  logic               rd_vld;
  logic               busy;
  logic               snap_done;
  logic               overrun;

  status_snapshot_ctrl #(
    .N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .PERIOD(PERIOD), .AW(AW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .status_in(status_in), .snap_mode(snap_mode), .snap_req(snap_req),
    .chg_clr(chg_clr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_vld(rd_vld), .busy(busy),
    .snap_done(snap_done), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int             phase;
    logic [AW-1:0]  addr;
    logic [63:0]    exp;
  } rvec_t;

  rvec_t tbl [40];
  int    n_tbl = 0;
  int    n_pass = 0;
  int    n_total = 0;

  task automatic add(input int ph, input logic [AW-1:0] a, input logic [31:0] hi, input logic [31:0] lo);
    tbl[n_tbl].phase = ph;
    tbl[n_tbl].addr  = a;
    tbl[n_tbl].exp   = {hi, lo};
    n_tbl++;
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Back-to-back reads of every table entry of one phase; result of read i is due two cycles later.
  task automatic run_reads(input int ph);
    int q[$];
    for (int i = 0; i < n_tbl; i++)
      if (tbl[i].phase == ph) q.push_back(i);
    for (int i = 0; i < q.size() + 2; i++) begin
      if (i >= 2)
        chk($sformatf("rd_p%0d_pair%0d", ph, tbl[q[i-2]].addr), {rd_vld, rd_data}, {1'b1, tbl[q[i-2]].exp});
      if (i < q.size()) begin
        rd_en   = 1'b1;
        rd_addr = tbl[q[i]].addr;
      end else begin
        rd_en = 1'b0;
      end
      tick();
    end
  endtask

  task automatic read_pair(input string name, input logic [AW-1:0] a, input logic [63:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({name, "_t1"}, {64'd0, rd_vld}, 65'd0);
    tick();
    chk(name, {rd_vld, rd_data}, {1'b1, exp});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (snap_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(name, {64'd0, snap_done}, 65'd1);
    tick();
  endtask

  // Leaves the bench at the negedge of the CAPTURE cycle.
  task automatic od_scan();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  function automatic logic [N_CH*DW-1:0] st(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    int cnt;
    int wcyc;
    logic seen;

    add(1, 7'd0,  32'd2, 32'hA);
    add(1, 7'd1,  32'hB, 32'hC);
    add(1, 7'd2,  32'hD, 32'hF);
    add(1, 7'd64, 32'hC0DE0000, 32'hC0DE0001);
    add(2, 7'd0,  32'd3, 32'hA);
    add(2, 7'd2,  32'hD, 32'hF);
    add(3, 7'd2,  32'hD, 32'hF);
    add(4, 7'd0,  32'd4, 32'h55);
    add(4, 7'd2,  32'hD, 32'h1);
    add(5, 7'd0,  32'd5, 32'h11);
    add(5, 7'd1,  32'h22, 32'h33);
    add(5, 7'd2,  32'h44, 32'hF);
    add(5, 7'd65, 32'hBEEF0002, 32'h1234);
    add(6, 7'd0,  32'd6, 32'h11);
    add(6, 7'd2,  32'h44, 32'h0);
    add(7, 7'd1,  32'h22, 32'h77);
    add(7, 7'd2,  32'h44, 32'h4);
    add(8, 7'd1,  32'h66, 32'h77);
    add(8, 7'd2,  32'h44, 32'h2);
    add(9, 7'd0,  32'd9, 32'h11);
    add(9, 7'd2,  32'h44, 32'h2);
    add(10, 7'd0, 32'd10, 32'h11);
    add(10, 7'd1, 32'h66, 32'h77);
    add(10, 7'd2, 32'h44, 32'h2);
    add(11, 7'd0, 32'd1, 32'h11);
    add(11, 7'd1, 32'hAAAA, 32'h77);
    add(11, 7'd2, 32'h44, 32'hF);

    rst = 1'b1; cmd_en = 1'b0; cmd_addr = '0; cmd_data = '0;
    status_in = st(32'hA, 32'hB, 32'hC, 32'hD);
    snap_mode = 1'b0; snap_req = 1'b0; chg_clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    chk("reset_outputs", {rd_vld, busy, snap_done, overrun, 61'd0}, 65'd0);
    chk("reset_rd_data", {1'b0, rd_data}, 65'd0);

    // Periodic mode: two scans in the first 100 cycles.
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (snap_done === 1'b1) cnt++;
    end
    chk("periodic_done_count", 65'(cnt), 65'd2);
    cmd_en = 1'b1; cmd_addr = 7'd0; cmd_data = 32'hC0DE0000; tick();
    cmd_addr = 7'd1; cmd_data = 32'hC0DE0001; tick();
    cmd_addr = 7'd2; cmd_data = 32'hBEEF0002; tick();
    cmd_en = 1'b0;
    snap_mode = 1'b1;
    run_reads(1);

    // Read and write of the same word in one cycle returns the old word.
    rd_en = 1'b1; rd_addr = 7'd64;
    cmd_en = 1'b1; cmd_addr = 7'd0; cmd_data = 32'hFFFF0000;
    tick();
    rd_en = 1'b0; cmd_en = 1'b0;
    tick();
    chk("rw_same_cycle", {rd_vld, rd_data}, {1'b1, 32'hC0DE0000, 32'hC0DE0001});
    read_pair("rw_after", 7'd64, {32'hFFFF0000, 32'hC0DE0001});

    // Coherence: channel 0 changes during WRITE.
    od_scan();
    chk("busy_capture", {64'd0, busy}, 65'd1);
    tick();
    status_in = st(32'h55, 32'hB, 32'hC, 32'hD);
    wait_done("done_scan3");
    run_reads(2);
    chg_clr = 1'b1; tick(); chg_clr = 1'b0;
    run_reads(3);
    od_scan();
    wait_done("done_scan4");
    run_reads(4);

    // Command writes on alternate WRITE cycles stall the scan.
    status_in = st(32'h11, 32'h22, 32'h33, 32'h44);
    od_scan();
    tick();
    wcyc = -1;
    for (int j = 0; j < 30; j++) begin
      if (snap_done === 1'b1) begin
        wcyc = j;
        break;
      end
      cmd_en   = (j < 12) && (j % 2 == 0);
      cmd_addr = 7'd3;
      cmd_data = 32'h1234;
      tick();
    end
    cmd_en = 1'b0;
    chk("collision_write_cycles", 65'(wcyc), 65'd12);
    tick();
    run_reads(5);

    chg_clr = 1'b1; tick(); chg_clr = 1'b0;
    od_scan();
    wait_done("done_scan6");
    run_reads(6);

    status_in = st(32'h11, 32'h22, 32'h77, 32'h44);
    od_scan();
    wait_done("done_scan7");
    run_reads(7);

    // Clear coinciding with the change-word write.
    status_in = st(32'h11, 32'h66, 32'h77, 32'h44);
    od_scan();
    repeat (6) tick();
    chg_clr = 1'b1; tick(); chg_clr = 1'b0;
    wait_done("done_scan8");
    run_reads(8);

    // On-demand overrun.
    chk("overrun_clear", {64'd0, overrun}, 65'd0);
    snap_req = 1'b1; tick(); snap_req = 1'b0; tick();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("overrun_set", {64'd0, overrun}, 65'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (snap_done === 1'b1) cnt++;
      tick();
    end
    chk("ondemand_done_count", 65'(cnt), 65'd1);
    run_reads(9);
    seen = 1'b0;
    for (int i = 0; i < PERIOD + 6; i++) begin
      tick();
      if (busy === 1'b1) seen = 1'b1;
    end
    chk("no_periodic_in_ondemand", {64'd0, seen}, 65'd0);
    chk("overrun_sticky", {64'd0, overrun}, 65'd1);

    // Reset in WRITE index 2.
    status_in = st(32'h11, 32'hAAAA, 32'h77, 32'h44);
    od_scan();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midscan_rst_flags", {rd_vld, busy, snap_done, overrun, 61'd0}, 65'd0);
    chk("midscan_rst_rd_data", {1'b0, rd_data}, 65'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    run_reads(10);

    // First periodic trigger right after reset release.
    rst = 1'b1; snap_mode = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("trigger_after_rst", {64'd0, busy}, 65'd1);
    wait_done("done_after_rst");
    snap_mode = 1'b1;
    run_reads(11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
